dcache_responder: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache.
- Acts as the responder for the core's MEM-stage load/store requests and as the initiator toward a line-wide backing memory.
- Raises `miss_o` as the stall request consumed by the pipeline hazard controller. While it is high the controller stalls IF/ID/EX/MEM and bubbles WB.
- Sits between the core's MEM stage and the main-memory model.

---
 rtl/dcache_responder.sv | 161 ++++++++++++++++
 tb/tb_dcache_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache between the core MEM stage
// and a line-wide backing memory; miss_o stalls the pipeline while a line is swapped.
module dcache_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 4,
  localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN,
  localparam int LINE_WORDS   = 1 << LINE_ADDR_LEN,
  localparam int LINE_W       = 32 * LINE_WORDS,
  localparam int SETS         = 1 << SET_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_i,
  input  logic              wr_req_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wr_data_i,
  output logic [31:0]       rd_data_o,
  output logic              miss_o,
  output logic              mem_rd_req_o,
  output logic              mem_wr_req_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wr_line_o,
  input  logic [LINE_W-1:0] mem_rd_line_i,
  input  logic              mem_gnt_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWAP_OUT   = 2'd1,
    SWAP_IN    = 2'd2,
    SWAP_IN_OK = 2'd3
  } state_e;

  localparam logic [LINE_ADDR_LEN+1:0] LINE_OFFS_ZERO = '0;

  state_e                  state_q;
  logic [SETS-1:0]         valid_q;
  logic [SETS-1:0]         dirty_q;
  logic                    mem_rd_req_q;
  logic                    mem_wr_req_q;
  logic [31:0]             mem_addr_q;
  logic [31:0]             hit_cnt_q;
  logic [31:0]             miss_cnt_q;
  logic [SET_ADDR_LEN-1:0] set_q;
  logic [TAG_ADDR_LEN-1:0] req_tag_q;
  logic [LINE_W-1:0]       refill_q;

  logic [31:0]             data_mem_q [SETS][LINE_WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_mem_q  [SETS];

  logic                     req;
  logic                     hit;
  logic [LINE_ADDR_LEN-1:0] req_word;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [TAG_ADDR_LEN-1:0]  req_tag;
  logic                     unused_addr_bits;

  assign req_word         = addr_i[LINE_ADDR_LEN+1:2];
  assign req_set          = addr_i[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign req_tag          = addr_i[31 -: TAG_ADDR_LEN];
  assign unused_addr_bits = ^addr_i[1:0];

  assign req = rd_req_i | wr_req_i;
  assign hit = req && valid_q[req_set] && (tag_mem_q[req_set] == req_tag);

  // Hits are answered in the request cycle; any swap in progress keeps the stall up.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_data_o = '0;
    if (state_q == IDLE && hit) rd_data_o = data_mem_q[req_set][req_word];
    miss_o = (state_q != IDLE) || (req && !hit);
  end

  always_comb begin
    mem_wr_line_o = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      mem_wr_line_o[32*w +: 32] = data_mem_q[set_q][w];
    end
  end

  assign mem_rd_req_o = mem_rd_req_q;
  assign mem_wr_req_o = mem_wr_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

  // Control FSM: memory requests and address are registered and held until the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      set_q        <= '0;
      req_tag_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
            if (wr_req_i) dirty_q[req_set] <= 1'b1;
          end else if (req) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
            set_q      <= req_set;
            req_tag_q  <= req_tag;
            if (valid_q[req_set] && dirty_q[req_set]) begin
              state_q      <= SWAP_OUT;
              mem_wr_req_q <= 1'b1;
              mem_addr_q   <= {tag_mem_q[req_set], req_set, LINE_OFFS_ZERO};
            end else begin
              state_q      <= SWAP_IN;
              mem_rd_req_q <= 1'b1;
              mem_addr_q   <= {req_tag, req_set, LINE_OFFS_ZERO};
            end
          end
        end
        SWAP_OUT: begin
          if (mem_gnt_i) begin
            state_q      <= SWAP_IN;
            mem_wr_req_q <= 1'b0;
            mem_rd_req_q <= 1'b1;
            mem_addr_q   <= {req_tag_q, set_q, LINE_OFFS_ZERO};
          end
        end
        SWAP_IN: begin
          if (mem_gnt_i) begin
            state_q      <= SWAP_IN_OK;
            mem_rd_req_q <= 1'b0;
          end
        end
        SWAP_IN_OK: begin
          state_q        <= IDLE;
          valid_q[set_q] <= 1'b1;
          dirty_q[set_q] <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: data, tags and the refill buffer are storage qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == SWAP_IN && mem_gnt_i) refill_q <= mem_rd_line_i;
    if (state_q == SWAP_IN_OK) begin
      tag_mem_q[set_q] <= req_tag_q;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_mem_q[set_q][w] <= refill_q[32*w +: 32];
      end
    end else if (state_q == IDLE && wr_req_i && hit) begin
      data_mem_q[req_set][req_word] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a line-wide memory model answers refills and
// absorbs writebacks, with hand-computed expectations for each scenario.
module tb_dcache_responder;

  localparam int LINE_WORDS = 8;
  localparam int LINE_W     = 32 * LINE_WORDS;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req_i;
  logic              wr_req_i;
  logic [31:0]       addr_i;
  logic [31:0]       wr_data_i;
  logic [31:0]       rd_data_o;
  logic              miss_o;
  logic              mem_rd_req_o;
  logic              mem_wr_req_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_wr_line_o;
  logic [LINE_W-1:0] mem_rd_line_i;
  logic              mem_gnt_i;
  logic [31:0]       hit_cnt_o;
  logic [31:0]       miss_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem_model [logic [31:0]];

  dcache_responder dut (
    .clk           (clk),
    .rst           (rst),
    .rd_req_i      (rd_req_i),
    .wr_req_i      (wr_req_i),
    .addr_i        (addr_i),
    .wr_data_i     (wr_data_i),
    .rd_data_o     (rd_data_o),
    .miss_o        (miss_o),
    .mem_rd_req_o  (mem_rd_req_o),
    .mem_wr_req_o  (mem_wr_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_line_o (mem_wr_line_o),
    .mem_rd_line_i (mem_rd_line_i),
    .mem_gnt_i     (mem_gnt_i),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Untouched memory: word i of the line at L holds L*4 + i (so line 0x40 holds 0x100..0x107).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] line;
    line = {a[31:5], 5'b0};
    if (mem_model.exists(a)) return mem_model[a];
    return (line << 2) + 32'((a - line) >> 2);
  endfunction

  // Wait for the expected request, check it stays stable for `delay` cycles, then grant it.
  task automatic serve(input bit is_wr, input logic [31:0] exp_addr, input int delay,
                       input string tag);
    int   n;
    bit   stable;
    logic [31:0] a0;
    n = 0;
    while (!(is_wr ? mem_wr_req_o : mem_rd_req_o) && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'b0, (is_wr ? mem_wr_req_o : mem_rd_req_o)}, 32'd1);
    if (n >= 50) return;
    check({tag, "_addr"}, mem_addr_o, exp_addr);
    check({tag, "_other_req"}, {31'b0, (is_wr ? mem_rd_req_o : mem_wr_req_o)}, 32'd0);
    a0     = mem_addr_o;
    stable = 1'b1;
    repeat (delay) begin
      tick();
      if (!(is_wr ? mem_wr_req_o : mem_rd_req_o) || mem_addr_o !== a0 || !miss_o) stable = 1'b0;
    end
    check({tag, "_stable"}, {31'b0, stable}, 32'd1);
    if (is_wr) begin
      for (int w = 0; w < LINE_WORDS; w++) mem_model[exp_addr + 32'(4*w)] = mem_wr_line_o[32*w +: 32];
    end else begin
      for (int w = 0; w < LINE_WORDS; w++) mem_rd_line_i[32*w +: 32] = mem_word(exp_addr + 32'(4*w));
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i     = 1'b0;
    mem_rd_line_i = '0;
    check({tag, "_req_drop"}, {31'b0, (is_wr ? mem_wr_req_o : mem_rd_req_o)}, 32'd0);
    check({tag, "_miss_held"}, {31'b0, miss_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] mc;
    rst = 1'b1; rd_req_i = 1'b0; wr_req_i = 1'b0; addr_i = '0; wr_data_i = '0;
    mem_rd_line_i = '0; mem_gnt_i = 1'b0;
    tick(); tick();
    check("rst_miss", {31'b0, miss_o}, 32'd0);
    check("rst_rd_req", {31'b0, mem_rd_req_o}, 32'd0);
    check("rst_wr_req", {31'b0, mem_wr_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    check("rst_hit_cnt", hit_cnt_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
    rst = 1'b0;
    tick();

    // Cold load of 0x40
    rd_req_i = 1'b1; addr_i = 32'h40; #1;
    check("cold_miss_now", {31'b0, miss_o}, 32'd1);
    serve(1'b0, 32'h40, 2, "cold");
    tick();
    check("cold_hit_miss", {31'b0, miss_o}, 32'd0);
    check("cold_rd_data", rd_data_o, 32'h100);
    check("cold_miss_cnt", miss_cnt_o, 32'd1);
    tick();
    check("cold_hit_cnt", hit_cnt_o, 32'd1);

    // Zero-latency hit on 0x4C
    addr_i = 32'h4C; #1;
    check("hit_rd_data", rd_data_o, 32'h103);
    check("hit_miss", {31'b0, miss_o}, 32'd0);
    check("hit_no_mem", {31'b0, mem_rd_req_o | mem_wr_req_o}, 32'd0);
    tick();
    check("hit_cnt2", hit_cnt_o, 32'd2);

    // Dirty eviction: store hit to 0x44, then conflicting load of 0x1044
    rd_req_i = 1'b0; wr_req_i = 1'b1; addr_i = 32'h44; wr_data_i = 32'hDEAD_BEEF; #1;
    check("st_hit_miss", {31'b0, miss_o}, 32'd0);
    tick();
    wr_req_i = 1'b0; rd_req_i = 1'b1; addr_i = 32'h1044; #1;
    mc = miss_cnt_o;
    check("evict_miss_now", {31'b0, miss_o}, 32'd1);
    tick();
    check("evict_wr_req", {31'b0, mem_wr_req_o}, 32'd1);
    check("evict_word1", mem_wr_line_o[63:32], 32'hDEAD_BEEF);
    check("evict_word0", mem_wr_line_o[31:0], 32'h100);
    serve(1'b1, 32'h40, 0, "evict_wb");
    serve(1'b0, 32'h1040, 1, "evict_fill");
    tick();
    check("evict_rd_data", rd_data_o, 32'h4101);
    check("evict_miss_cnt", miss_cnt_o, mc + 32'd1);
    check("evict_mem_word1", mem_word(32'h44), 32'hDEAD_BEEF);

    // Store miss on clean set 0, then conflicting load forces writeback
    rd_req_i = 1'b0; wr_req_i = 1'b1; addr_i = 32'h2000; wr_data_i = 32'h1234_5678; #1;
    check("stmiss_miss_now", {31'b0, miss_o}, 32'd1);
    serve(1'b0, 32'h2000, 1, "stmiss_fill");
    tick();
    check("stmiss_hit", {31'b0, miss_o}, 32'd0);
    tick();
    wr_req_i = 1'b0; rd_req_i = 1'b1; addr_i = 32'h3000; #1;
    check("conflict_miss", {31'b0, miss_o}, 32'd1);
    serve(1'b1, 32'h2000, 0, "conflict_wb");
    check("conflict_wb_word0", mem_word(32'h2000), 32'h1234_5678);
    check("conflict_wb_word1", mem_word(32'h2004), 32'h8001);
    serve(1'b0, 32'h3000, 20, "slow");
    tick();
    check("slow_rd_data", rd_data_o, 32'hC000);

    // Stray grant in IDLE
    rd_req_i = 1'b0; mc = miss_cnt_o;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    check("stray_rd_req", {31'b0, mem_rd_req_o}, 32'd0);
    check("stray_wr_req", {31'b0, mem_wr_req_o}, 32'd0);
    check("stray_miss_cnt", miss_cnt_o, mc);
    rd_req_i = 1'b1; addr_i = 32'h3000; #1;
    check("stray_still_hit", {31'b0, miss_o}, 32'd0);
    check("stray_rd_data", rd_data_o, 32'hC000);
    tick();

    // Reset in SWAP_IN with a simultaneous grant
    addr_i = 32'h40; #1;
    check("rstmid_miss", {31'b0, miss_o}, 32'd1);
    tick();
    check("rstmid_in_swap", {31'b0, mem_rd_req_o}, 32'd1);
    rst = 1'b1; rd_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rd_line_i = '1;
    tick();
    rst = 1'b0; mem_gnt_i = 1'b0; mem_rd_line_i = '0;
    check("rstmid_rd_req", {31'b0, mem_rd_req_o}, 32'd0);
    check("rstmid_miss_o", {31'b0, miss_o}, 32'd0);
    check("rstmid_hit_cnt", hit_cnt_o, 32'd0);
    check("rstmid_miss_cnt", miss_cnt_o, 32'd0);
    rd_req_i = 1'b1; addr_i = 32'h3000; #1;
    check("rstmid_lost_line", {31'b0, miss_o}, 32'd1);
    rd_req_i = 1'b1; addr_i = 32'h40; #1;
    check("rstmid_reload_miss", {31'b0, miss_o}, 32'd1);
    serve(1'b0, 32'h40, 1, "reload");
    tick();
    check("reload_rd_data", rd_data_o, 32'h100);
    check("reload_miss_cnt", miss_cnt_o, 32'd1);
    rd_req_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
